// File: rtl/inst_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// Holds default widths, the FIFO entry layout and reset values.
package inst_prefetch_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_entry_t;

    localparam logic [ADDR_W-1:0] PC_RST    = '0;
    localparam logic [DATA_W-1:0] INSTR_RST = '0;

endpackage

// File: rtl/inst_prefetch_if.sv
// Bundles the memory port, redirect input and instruction handshake of the prefetcher.
// The master modport is the prefetcher's view; slave is the surroundings' view.
interface inst_prefetch_if #(
    parameter int ADDR_W = inst_prefetch_pkg::ADDR_W,
    parameter int DATA_W = inst_prefetch_pkg::DATA_W,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_busy;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              ins_valid;
    logic [DATA_W-1:0] ins_data;
    logic [ADDR_W-1:0] ins_pc;
    logic              ins_ready;
    logic [CNT_W-1:0]  count;

    modport master (
        output mem_rd, mem_addr, ins_valid, ins_data, ins_pc, count,
        input  mem_data, mem_busy, redirect, redirect_addr, ins_ready
    );

    modport slave (
        input  mem_rd, mem_addr, ins_valid, ins_data, ins_pc, count,
        output mem_data, mem_busy, redirect, redirect_addr, ins_ready
    );

endinterface

// File: rtl/prefetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush and asynchronous clear.
// When empty the head output keeps showing the last entry that was at the head.
module prefetch_fifo #(
    parameter type entry_t = inst_prefetch_pkg::fetch_entry_t,
    parameter int  DEPTH   = 4,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  entry_t           push_entry,
    input  logic             pop,
    input  logic             flush,
    output entry_t           head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);
    import inst_prefetch_pkg::*;

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    entry_t           mem_reg [DEPTH];
    entry_t           last_reg;
    logic [PTR_W-1:0] wr_reg;
    logic [PTR_W-1:0] rd_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid   = (count_reg != '0);
    assign push_ok = push && (count_reg != FULL_CNT);
    assign pop_ok  = pop && valid;
    assign head    = valid ? mem_reg[rd_reg] : last_reg;
    assign count   = count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            last_reg  <= '0;
            wr_reg    <= '0;
            rd_reg    <= '0;
            count_reg <= '0;
        end else begin
            if (valid) begin
                last_reg <= mem_reg[rd_reg];
            end
            if (flush) begin
                wr_reg    <= '0;
                rd_reg    <= '0;
                count_reg <= '0;
            end else begin
                if (push_ok) begin
                    mem_reg[wr_reg] <= push_entry;
                    wr_reg          <= ptr_inc(wr_reg);
                end
                if (pop_ok) begin
                    rd_reg <= ptr_inc(rd_reg);
                end
                case ({push_ok, pop_ok})
                    2'b10:   count_reg <= count_reg + CNT_W'(1);
                    2'b01:   count_reg <= count_reg - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: issues reads ahead of the controller, tags each byte
// with its address and queues it; yields memory to the datapath and flushes on jumps.
module inst_prefetch #(
    parameter int ADDR_W = inst_prefetch_pkg::ADDR_W,
    parameter int DATA_W = inst_prefetch_pkg::DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst,
    inst_prefetch_if.master bus
);
    import inst_prefetch_pkg::*;

    localparam int             CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] fpc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              issue;
    logic              push;
    logic              pop;
    logic              head_valid;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    entry_t            push_entry;
    entry_t            head;

    // Credits use the registered count, so a pop only frees a slot a cycle later.
    assign occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign issue      = !rst && !bus.mem_busy && !bus.redirect && (occupancy < DEPTH_C);
    assign push       = inflight && !bus.redirect;
    assign pop        = head_valid && bus.ins_ready && !bus.redirect;
    assign push_entry = '{pc: inflight_pc, instr: bus.mem_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc         <= ADDR_W'(PC_RST);
            inflight    <= 1'b0;
            inflight_pc <= ADDR_W'(PC_RST);
        end else if (bus.redirect) begin
            fpc      <= bus.redirect_addr;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fpc         <= fpc + ADDR_W'(1);
                inflight_pc <= fpc;
            end
        end
    end

    prefetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (bus.redirect),
        .head       (head),
        .valid      (head_valid),
        .count      (count)
    );

    assign bus.mem_rd    = issue;
    assign bus.mem_addr  = fpc;
    assign bus.ins_valid = head_valid;
    assign bus.ins_data  = head.instr;
    assign bus.ins_pc    = head.pc;
    assign bus.count     = count;

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch: fill, drain, redirect, wrap, memory stall
// and asynchronous reset, against a ROM with ROM[i] = 8'h20 + i.
module tb_inst_prefetch;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    logic [DATA_W-1:0] rom [32];

    inst_prefetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    inst_prefetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Program memory: data appears the cycle after an accepted read.
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_data <= rom[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] wrap_addr [4];
        logic [7:0] wrap_data [4];
        logic       stall_v   [8];
        logic [4:0] stall_pc  [8];
        logic       found;

        for (int i = 0; i < 32; i++) rom[i] = 8'h20 + 8'(i);
        wrap_addr = '{5'h1E, 5'h1F, 5'h00, 5'h01};
        wrap_data = '{8'h3E, 8'h3F, 8'h20, 8'h21};
        stall_v   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        stall_pc  = '{5'h02, 5'h03, 5'h04, 5'h00, 5'h00, 5'h05, 5'h06, 5'h07};

        rst               = 1'b1;
        bus.mem_busy      = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        bus.ins_ready     = 1'b0;

        // Reset state
        #2;
        check("rst_valid", bus.ins_valid, 0);
        check("rst_count", bus.count, 0);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_ins_data", bus.ins_data, 0);
        check("rst_ins_pc", bus.ins_pc, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill with ins_ready low: four requests then stop
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("fill_rd", bus.mem_rd, (i < 4));
            if (i < 4) check("fill_addr", bus.mem_addr, i);
            check("fill_valid", bus.ins_valid, (i >= 2));
            next_cycle();
        end
        check("full_count", bus.count, 4);
        check("full_data", bus.ins_data, 8'h20);
        check("full_pc", bus.ins_pc, 0);

        // Drain: one instruction per cycle, no gaps
        bus.ins_ready = 1'b1;
        for (int d = 0; d < 12; d++) begin
            @(negedge clk);
            check("drain_valid", bus.ins_valid, 1);
            check("drain_pc", bus.ins_pc, d);
            check("drain_data", bus.ins_data, 8'h20 + d);
            check("drain_count", bus.count, (d == 0) ? 4 : (d == 1) ? 3 : 2);
            check("drain_rd", bus.mem_rd, (d >= 1));
            if (d >= 1) check("drain_addr", bus.mem_addr, 3 + d);
            next_cycle();
        end

        // Redirect to 1C in a response cycle
        bus.redirect      = 1'b1;
        bus.redirect_addr = 5'h1C;
        bus.ins_ready     = 1'b0;
        @(negedge clk);
        check("redir_rd", bus.mem_rd, 0);
        next_cycle();
        bus.redirect = 1'b0;
        @(negedge clk);
        check("redir1_count", bus.count, 0);
        check("redir1_valid", bus.ins_valid, 0);
        check("redir1_rd", bus.mem_rd, 1);
        check("redir1_addr", bus.mem_addr, 5'h1C);
        check("redir1_hold_pc", bus.ins_pc, 5'h0C);
        check("redir1_hold_data", bus.ins_data, 8'h2C);
        next_cycle();
        @(negedge clk);
        check("redir2_valid", bus.ins_valid, 0);
        check("redir2_addr", bus.mem_addr, 5'h1D);
        next_cycle();
        @(negedge clk);
        check("redir3_valid", bus.ins_valid, 1);
        check("redir3_pc", bus.ins_pc, 5'h1C);
        check("redir3_data", bus.ins_data, 8'h3C);
        check("redir3_count", bus.count, 1);
        next_cycle();

        // Wrap: redirect to 1E
        bus.redirect      = 1'b1;
        bus.redirect_addr = 5'h1E;
        @(negedge clk);
        check("wrap_redir_rd", bus.mem_rd, 0);
        next_cycle();
        bus.redirect = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("wrap_rd", bus.mem_rd, (k < 4));
            if (k < 4) check("wrap_addr", bus.mem_addr, wrap_addr[k]);
            next_cycle();
        end
        bus.ins_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("wrap_valid", bus.ins_valid, 1);
            check("wrap_pc", bus.ins_pc, wrap_addr[k]);
            check("wrap_data", bus.ins_data, wrap_data[k]);
            next_cycle();
        end

        // mem_busy for three cycles mid-stream
        for (int k = 0; k < 8; k++) begin
            bus.mem_busy = (k < 3);
            @(negedge clk);
            check("stall_rd", bus.mem_rd, (k >= 3));
            if (k >= 3) check("stall_addr", bus.mem_addr, k + 2);
            check("stall_valid", bus.ins_valid, stall_v[k]);
            if (stall_v[k]) begin
                check("stall_pc", bus.ins_pc, stall_pc[k]);
                check("stall_data", bus.ins_data, 8'h20 + 8'(stall_pc[k]));
            end
            next_cycle();
        end

        // Asynchronous reset between edges once count reaches 3
        bus.mem_busy  = 1'b0;
        bus.ins_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (bus.count == 3) found = 1'b1;
            else next_cycle();
        end
        check("reach_count3", found, 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", bus.ins_valid, 0);
        check("arst_count", bus.count, 0);
        check("arst_rd", bus.mem_rd, 0);
        check("arst_addr", bus.mem_addr, 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rd", bus.mem_rd, 1);
        check("post_rst_addr", bus.mem_addr, 0);
        check("post_rst_valid", bus.ins_valid, 0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("post_rst_valid2", bus.ins_valid, 1);
        check("post_rst_pc", bus.ins_pc, 0);
        check("post_rst_data", bus.ins_data, 8'h20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_prefetch.md
# inst_prefetch

Instruction prefetch unit sitting directly upstream of the stack-machine controller/IR. It streams 8-bit instructions from program memory into a small FIFO, tagging each with its 5-bit address, and hands them to the controller via valid/ready. It yields the memory port whenever the datapath needs it for load/store, and flushes on jump redirects.

## Interface
- `ADDR_W`, default 5: address width; PC wraps modulo 2^ADDR_W.
- `DATA_W`, default 8: instruction width.
- `DEPTH`, default 4: FIFO entries; any value ≥ 2.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `mem_rd`, output, 1: read request; the memory samples it on the rising edge.
- `mem_addr`, output, ADDR_W: read address, equal to the fetch PC.
- `mem_data`, input, DATA_W: read data, valid the cycle after an accepted `mem_rd`.
- `mem_busy`, input, 1: the datapath owns memory this cycle; the block issues no request.
- `redirect`, input, 1: jump taken, one-cycle pulse.
- `redirect_addr`, input, ADDR_W: jump target.
- `ins_valid`, output, 1: FIFO head holds an instruction.
- `ins_data`, output, DATA_W: head instruction.
- `ins_pc`, output, ADDR_W: address of the head instruction.
- `ins_ready`, input, 1: the controller consumes the head when `ins_valid` is high.
- `count`, output, clog2(DEPTH+1): number of FIFO entries occupied.

## Operation
- State:
  - fetch PC `fpc`.
  - `inflight` flag, a registered copy of `mem_rd`.
  - `inflight_pc`.
  - FIFO of {pc, instr}.
- Issue rule (combinational):
  - `mem_rd = !mem_busy && !redirect && (count + inflight) < DEPTH`.
  - `mem_addr = fpc`.
  - On issue, `fpc <= fpc + 1` (wraps: 5'h1F → 5'h00).
  - Sets `inflight`; `inflight_pc <= fpc`.
- Response:
  - When `inflight` is high, `{inflight_pc, mem_data}` is pushed at the end of that cycle, unless `redirect` is high that cycle (response discarded).
- Pop:
  - `ins_valid && ins_ready` removes the head.
  - A pop frees no issue credit until the following cycle (the conservative credit rule).
- Simultaneous push and pop: `count` is unchanged and order is preserved. A push into an empty FIFO becomes visible the next cycle (no bypass).
- Redirect has priority over everything:
  - The FIFO is flushed and `count <= 0`.
  - Any in-flight response is dropped.
  - `fpc <= redirect_addr` and `inflight <= 0`.
  - A pop in the same cycle is ignored.
  - No request is issued in the redirect cycle.
- Full FIFO (`count + inflight == DEPTH`): no request. Empty FIFO: `ins_valid = 0`, and `ins_data`/`ins_pc` hold their last values.
- `mem_busy` only suppresses issue. A response already in flight is still captured.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `fpc = 0`, `inflight = 0`, `count = 0`.
  - `ins_valid = 0`, `ins_data = 0`, `ins_pc = 0`.
  - `mem_rd = 0` while `rst` is high; `mem_addr = 0`.
  - FIFO contents are cleared.
- Reset mid-operation discards everything, including in-flight reads.
- Fetch latency:
  - Cycle 0: `mem_rd` high with address A.
  - Cycle 1: data returns.
  - Cycle 2: `ins_valid` high with `ins_pc = A`.
- Redirect at cycle t gives the first request at t+1 to the target and `ins_valid` for the target at t+3.
- Steady state with `ins_ready` held high: one instruction per cycle after the pipeline fills.

## Structure
- Shared package holds:
  - `ADDR_W` and `DATA_W` constants.
  - Struct `fetch_entry_t` {pc, instr}.
  - Reset values.
- Sub-module `prefetch_fifo`:
  - Parameterized synchronous FIFO of `fetch_entry_t`.
  - Ports: push, pop, flush, count.
  - Asynchronous clear.
- The top level holds `fpc`, the in-flight tracking and the issue logic.

## Test plan
- Reset then fill: ROM[i] = 8'h20+i, `ins_ready = 0`.
  - Exactly 4 requests to addresses 0–3, then `mem_rd` stays 0.
  - `count = 4`, `ins_data = 8'h20`, `ins_pc = 0`.
- Drain: from the full state, hold `ins_ready = 1`.
  - Outputs 8'h20, 8'h21, … one per cycle with matching `ins_pc`.
  - No gaps after the first refill.
- Redirect with a read in flight: redirect to 5'h1C in the response cycle.
  - The response is discarded and `count = 0`.
  - A request to 5'h1C at t+1; `ins_pc = 5'h1C` valid at t+3.
- Wrap: redirect to 5'h1E.
  - Requests 5'h1E, 5'h1F, 5'h00, 5'h01.
  - `ins_pc` follows the same order.
- `mem_busy` high for 3 cycles mid-stream.
  - No `mem_rd` during those cycles; the in-flight response is still captured.
  - Sequence continuity is preserved and no entry is duplicated or lost.
- Asynchronous reset asserted between clock edges at `count = 3`.
  - `ins_valid`, `count` and `mem_rd` go to 0 before the next edge.
  - The first post-reset request is to address 0.
